// File: rtl/decode_dispatch_pkg.sv
// Shared constants for the decode/dispatch stage: RV32I opcodes, ALU op codes,
// ROB entry kinds and the field layout of the outgoing ROB/ALU/branch/rename buses.
package decode_dispatch_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [3:0] {
        SIMP_ADD, SIMP_SUB, SIMP_SLL, SIMP_SLT, SIMP_SLTU, SIMP_XOR,
        SIMP_SRL, SIMP_SRA, SIMP_OR, SIMP_AND, SIMP_JALR
    } simp_op_t;

    typedef enum logic [1:0] {KIND_REG, KIND_BRANCH, KIND_JUMP} rob_kind_t;

    typedef enum logic {ST_RUN, ST_WAIT_JALR} state_t;

    // A lock is {locked, rob_index}; the MSB alone says whether the source waits on the ROB.
    localparam int SIMP_W = 4;
    localparam int KIND_W = 2;
    localparam int RD_W   = 5;

    // Bus layouts, MSB first:
    //   rob: {kind, rd, resolved, taken, value, pc}
    //   alu: {simp_op, tag, op1{lock,data}, op2{lock,data}}
    //   bra: {funct3, tag, op1{lock,data}, op2{lock,data}, target, predicted}
    //   reg: {rd, tag}
    function automatic int opnd_w(input int xlen, input int rob_w);
        return xlen + rob_w + 1;
    endfunction
    function automatic int rob_bus_w(input int xlen);
        return KIND_W + RD_W + 2 + 2 * xlen;
    endfunction
    function automatic int alu_bus_w(input int xlen, input int rob_w);
        return SIMP_W + rob_w + 2 * opnd_w(xlen, rob_w);
    endfunction
    function automatic int bra_bus_w(input int xlen, input int rob_w);
        return 3 + rob_w + 2 * opnd_w(xlen, rob_w) + xlen + 1;
    endfunction
    function automatic int reg_bus_w(input int rob_w);
        return RD_W + rob_w;
    endfunction

    // Field offsets for the default configuration (XLEN=32, ROB_W=3).
    localparam int ROB_PC_LSB       = 0;
    localparam int ROB_VALUE_LSB    = 32;
    localparam int ROB_TAKEN_BIT    = 64;
    localparam int ROB_RESOLVED_BIT = 65;
    localparam int ROB_RD_LSB       = 66;
    localparam int ROB_KIND_LSB     = 71;
    localparam int ALU_OP2_LSB      = 0;
    localparam int ALU_OP1_LSB      = 36;
    localparam int ALU_TAG_LSB      = 72;
    localparam int ALU_SIMP_LSB     = 75;
    localparam int BRA_PRED_BIT     = 0;
    localparam int BRA_TARGET_LSB   = 1;
    localparam int BRA_OP2_LSB      = 33;
    localparam int BRA_OP1_LSB      = 69;
    localparam int BRA_TAG_LSB      = 105;
    localparam int BRA_F3_LSB       = 108;

    function automatic simp_op_t alu_simp(input logic [2:0] f3, input logic f7b, input logic is_reg);
        case (f3)
            3'b000:  return (is_reg && f7b) ? SIMP_SUB : SIMP_ADD;
            3'b001:  return SIMP_SLL;
            3'b010:  return SIMP_SLT;
            3'b011:  return SIMP_SLTU;
            3'b100:  return SIMP_XOR;
            3'b101:  return f7b ? SIMP_SRA : SIMP_SRL;
            3'b110:  return SIMP_OR;
            default: return SIMP_AND;
        endcase
    endfunction

endpackage

// File: rtl/decode_dispatch_if.sv
// Bundle of fetch, register-file, ROB, execution-unit and predictor signals around the
// decode/dispatch stage; master is the dispatcher's view, slave the surrounding pipeline's.
interface decode_dispatch_if
    import decode_dispatch_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int ROB_W      = 3,
    parameter int BHW        = 4,
    parameter int BRA_ADDR_W = 6
);
    localparam int ROB_BUS_W = rob_bus_w(XLEN);
    localparam int ALU_BUS_W = alu_bus_w(XLEN, ROB_W);
    localparam int BRA_BUS_W = bra_bus_w(XLEN, ROB_W);
    localparam int REG_BUS_W = reg_bus_w(ROB_W);

    logic                  inst_valid;
    logic [31:0]           inst_in;
    logic [XLEN-1:0]       inst_pc;
    logic                  inst_ready;
    logic                  flush;
    logic                  redirect_valid;
    logic [XLEN-1:0]       redirect_pc;
    logic [4:0]            reg_name1, reg_name2;
    logic [ROB_W:0]        reg_lock1, reg_lock2;
    logic [XLEN-1:0]       reg_data1, reg_data2;
    logic [ROB_W-1:0]      rob_value_entry1, rob_value_entry2;
    logic                  rob_value_enable1, rob_value_enable2;
    logic [XLEN-1:0]       rob_value1, rob_value2;
    logic                  rob_stall;
    logic [ROB_W-1:0]      rob_rd_lock;
    logic                  rob_write;
    logic [ROB_BUS_W-1:0]  rob_bus;
    logic                  reg_write;
    logic [REG_BUS_W-1:0]  reg_bus;
    logic                  alu_stall, alu_write;
    logic [ALU_BUS_W-1:0]  alu_bus;
    logic                  bra_stall, bra_write;
    logic [BRA_BUS_W-1:0]  bra_bus;
    logic [BHW-1:0]        brp_pattern;
    logic [BRA_ADDR_W-1:0] brp_addr;
    logic                  branch_prediction;
    logic                  illegal;

    modport master (
        input  inst_valid, inst_in, inst_pc, flush, reg_lock1, reg_lock2, reg_data1, reg_data2,
               rob_value_enable1, rob_value_enable2, rob_value1, rob_value2, rob_stall,
               rob_rd_lock, alu_stall, bra_stall, branch_prediction,
        output inst_ready, redirect_valid, redirect_pc, reg_name1, reg_name2,
               rob_value_entry1, rob_value_entry2, rob_write, rob_bus, reg_write, reg_bus,
               alu_write, alu_bus, bra_write, bra_bus, brp_pattern, brp_addr, illegal
    );

    modport slave (
        output inst_valid, inst_in, inst_pc, flush, reg_lock1, reg_lock2, reg_data1, reg_data2,
               rob_value_enable1, rob_value_enable2, rob_value1, rob_value2, rob_stall,
               rob_rd_lock, alu_stall, bra_stall, branch_prediction,
        input  inst_ready, redirect_valid, redirect_pc, reg_name1, reg_name2,
               rob_value_entry1, rob_value_entry2, rob_write, rob_bus, reg_write, reg_bus,
               alu_write, alu_bus, bra_write, bra_bus, brp_pattern, brp_addr, illegal
    );

endinterface

// File: rtl/decode_dispatch_inst_fifo.sv
// Circular instruction buffer; clear drops every entry (including a same-cycle push).
module inst_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr, wr_ptr;
    logic             do_push, do_pop;

    assign do_push = push && (count != FULL);
    assign do_pop  = pop && !empty;
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/decode_dispatch.sv
// Decodes the instruction-buffer head, resolves its operands against the register file and
// ROB, and dispatches it to the ROB, rename table, ALU or branch unit with registered strobes.
module decode_dispatch
    import decode_dispatch_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int DEPTH      = 4,
    parameter int ROB_W      = 3,
    parameter int BHW        = 4,
    parameter int BRA_ADDR_W = 6
) (
    input logic              clk,
    input logic              rst,
    decode_dispatch_if.master io
);
    localparam int LW  = ROB_W + 1;
    localparam int OPW = XLEN + LW;
    localparam int FW  = XLEN + 32;
    localparam int CW  = $clog2(DEPTH) + 1;

    state_t          state;
    logic [BHW-1:0]  history;
    logic [FW-1:0]   head;
    logic [CW-1:0]   count;
    logic            empty, push, pop, clear;
    logic [31:0]     inst;
    logic [XLEN-1:0] pc, imm_i, imm_b, imm_u, imm_j, link, br_target, jal_target, jalr_target, redir_pc;
    logic [OPW-1:0]  opnd1, opnd2, alu_a, alu_b;
    logic            locked1, br_resolved, taken_local, taken;
    logic            is_br, is_jal, is_jalr, legal, needs_alu, needs_bra, writes_rd, unit_ok;
    logic            fire, pop_illegal, redirect_now, discard;
    simp_op_t        simp;
    rob_kind_t       rob_kind;
    logic            rob_resolved;
    logic [XLEN-1:0] rob_value;

    function automatic logic [OPW-1:0] resolve(input logic [LW-1:0] lock, input logic [XLEN-1:0] rf,
                                               input logic en, input logic [XLEN-1:0] rv);
        if (!lock[LW-1]) return {LW'(0), rf};
        if (en)          return {LW'(0), rv};
        return {lock, XLEN'(0)};
    endfunction

    inst_fifo #(.WIDTH(FW), .DEPTH(DEPTH)) u_fifo (
        .clk(clk), .rst(rst), .clear(clear), .push(push), .push_data({io.inst_pc, io.inst_in}),
        .pop(pop), .head(head), .count(count), .empty(empty)
    );

    assign inst  = head[31:0];
    assign pc    = head[FW-1:32];
    assign imm_i = XLEN'($signed(inst[31:20]));
    assign imm_b = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({inst[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
    assign link        = pc + XLEN'(4);
    assign br_target   = pc + imm_b;
    assign jal_target  = pc + imm_j;

    assign io.reg_name1        = inst[19:15];
    assign io.reg_name2        = inst[24:20];
    assign io.rob_value_entry1 = io.reg_lock1[ROB_W-1:0];
    assign io.rob_value_entry2 = io.reg_lock2[ROB_W-1:0];
    assign io.brp_pattern      = history;
    assign io.brp_addr         = pc[BRA_ADDR_W+1:2];
    assign io.inst_ready       = (count < CW'(DEPTH)) && (state == ST_RUN);

    assign opnd1       = resolve(io.reg_lock1, io.reg_data1, io.rob_value_enable1, io.rob_value1);
    assign opnd2       = resolve(io.reg_lock2, io.reg_data2, io.rob_value_enable2, io.rob_value2);
    assign locked1     = opnd1[OPW-1];
    assign br_resolved = !opnd1[OPW-1] && !opnd2[OPW-1];
    assign jalr_target = (opnd1[XLEN-1:0] + imm_i) & ~XLEN'(1);

    always_comb begin
        case (inst[14:12])
            F3_BEQ:  taken_local = (opnd1[XLEN-1:0] == opnd2[XLEN-1:0]);
            F3_BNE:  taken_local = (opnd1[XLEN-1:0] != opnd2[XLEN-1:0]);
            F3_BLT:  taken_local = ($signed(opnd1[XLEN-1:0]) <  $signed(opnd2[XLEN-1:0]));
            F3_BGE:  taken_local = ($signed(opnd1[XLEN-1:0]) >= $signed(opnd2[XLEN-1:0]));
            F3_BLTU: taken_local = (opnd1[XLEN-1:0] <  opnd2[XLEN-1:0]);
            F3_BGEU: taken_local = (opnd1[XLEN-1:0] >= opnd2[XLEN-1:0]);
            default: taken_local = 1'b0;
        endcase
    end
    assign taken = br_resolved ? taken_local : io.branch_prediction;

    // Per-opcode routing: which unit the head needs and what the ROB entry records.
    always_comb begin
        legal = 1'b0; needs_alu = 1'b0; needs_bra = 1'b0; writes_rd = 1'b0;
        simp = SIMP_ADD; alu_a = '0; alu_b = '0;
        rob_kind = KIND_REG; rob_resolved = 1'b0; rob_value = '0;
        case (inst[6:0])
            OPC_OP: begin
                legal = 1'b1; needs_alu = 1'b1; writes_rd = 1'b1;
                simp = alu_simp(inst[14:12], inst[30], 1'b1); alu_a = opnd1; alu_b = opnd2;
            end
            OPC_OPIMM: begin
                legal = 1'b1; needs_alu = 1'b1; writes_rd = 1'b1;
                simp = alu_simp(inst[14:12], inst[30], 1'b0); alu_a = opnd1; alu_b = {LW'(0), imm_i};
            end
            OPC_LUI: begin
                legal = 1'b1; writes_rd = 1'b1; rob_resolved = 1'b1; rob_value = imm_u;
            end
            OPC_AUIPC: begin
                legal = 1'b1; needs_alu = 1'b1; writes_rd = 1'b1;
                alu_a = {LW'(0), pc}; alu_b = {LW'(0), imm_u};
            end
            OPC_JAL: begin
                legal = 1'b1; needs_alu = 1'b1; writes_rd = 1'b1;
                alu_a = {LW'(0), pc}; alu_b = {LW'(0), XLEN'(4)};
            end
            OPC_JALR: begin
                legal = (inst[14:12] == 3'b000); writes_rd = 1'b1; rob_value = link;
                if (locked1) begin
                    needs_alu = 1'b1; simp = SIMP_JALR; rob_kind = KIND_JUMP;
                    alu_a = opnd1; alu_b = {LW'(0), imm_i};
                end else begin
                    rob_resolved = 1'b1;
                end
            end
            OPC_BRANCH: begin
                legal = (inst[14:13] != 2'b01); needs_bra = 1'b1; rob_kind = KIND_BRANCH;
                rob_resolved = br_resolved; rob_value = br_target;
            end
            default: ;
        endcase
    end

    assign is_br   = (inst[6:0] == OPC_BRANCH);
    assign is_jal  = (inst[6:0] == OPC_JAL);
    assign is_jalr = (inst[6:0] == OPC_JALR);
    assign unit_ok = needs_bra ? !io.bra_stall : (needs_alu ? !io.alu_stall : 1'b1);
    assign fire        = !empty && (state == ST_RUN) && !io.flush && !io.rob_stall && unit_ok && legal;
    assign pop_illegal = !empty && (state == ST_RUN) && !io.flush && !legal;
    assign redirect_now = fire && ((is_br && taken) || is_jal || (is_jalr && !locked1));
    assign redir_pc     = is_jal ? jal_target : (is_jalr ? jalr_target : br_target);
    assign discard      = fire && (redirect_now || is_jalr);
    assign pop   = fire || pop_illegal;
    assign clear = io.flush || discard;
    assign push  = io.inst_valid && io.inst_ready;

    // Strobes, buses, branch history and the RUN/WAIT_JALR state all register here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
            history <= '0;
            io.rob_write <= 1'b0; io.reg_write <= 1'b0; io.alu_write <= 1'b0; io.bra_write <= 1'b0;
            io.redirect_valid <= 1'b0; io.redirect_pc <= '0; io.illegal <= 1'b0;
            io.rob_bus <= '0; io.reg_bus <= '0; io.alu_bus <= '0; io.bra_bus <= '0;
        end else begin
            io.rob_write      <= fire;
            io.reg_write      <= fire && writes_rd && (inst[11:7] != 5'd0);
            io.alu_write      <= fire && needs_alu;
            io.bra_write      <= fire && needs_bra && !br_resolved;
            io.illegal        <= pop_illegal;
            io.redirect_valid <= redirect_now;
            if (redirect_now) io.redirect_pc <= redir_pc;
            if (fire) begin
                io.rob_bus <= {rob_kind, (is_br ? 5'd0 : inst[11:7]), rob_resolved, (is_br && taken), rob_value, pc};
                io.reg_bus <= {inst[11:7], io.rob_rd_lock};
                io.alu_bus <= {simp, io.rob_rd_lock, alu_a, alu_b};
                io.bra_bus <= {inst[14:12], io.rob_rd_lock, opnd1, opnd2, br_target, io.branch_prediction};
            end
            if (fire && is_br) history <= {history[BHW-2:0], taken};
            if (io.flush)
                state <= ST_RUN;
            else if (fire && is_jalr && locked1)
                state <= ST_WAIT_JALR;
        end
    end

endmodule

// File: tb/tb_decode_dispatch.sv
// Directed bench for decode_dispatch: streaming ADDIs, stall/backpressure, branch resolve and
// predict, JAL/JALR redirects and the WAIT_JALR wait, illegal opcodes and mid-run reset.
module tb_decode_dispatch;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_asserts = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    decode_dispatch_if #(.XLEN(32), .ROB_W(3), .BHW(4), .BRA_ADDR_W(6)) io();

    decode_dispatch #(.XLEN(32), .DEPTH(4), .ROB_W(3), .BHW(4), .BRA_ADDR_W(6)) dut (
        .clk(clk), .rst(rst), .io(io)
    );

    task automatic step_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [31:0] inst, input logic [31:0] pc);
        io.inst_valid = 1'b1;
        io.inst_in    = inst;
        io.inst_pc    = pc;
        step_cycle();
        io.inst_valid = 1'b0;
    endtask

    task automatic check_output(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        n_asserts++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] enc_addi(input int rd, input int imm);
        return (32'(imm) << 20) | (32'(rd) << 7) | 32'h13;
    endfunction

    function automatic logic [31:0] enc_add(input int rd);
        return (32'd2 << 20) | (32'd1 << 15) | (32'(rd) << 7) | 32'h33;
    endfunction

    initial begin
        io.inst_valid = 0; io.inst_in = '0; io.inst_pc = '0; io.flush = 0;
        io.reg_lock1 = '0; io.reg_lock2 = '0; io.reg_data1 = '0; io.reg_data2 = '0;
        io.rob_value_enable1 = 0; io.rob_value_enable2 = 0; io.rob_value1 = '0; io.rob_value2 = '0;
        io.rob_stall = 0; io.rob_rd_lock = 3'd5; io.alu_stall = 0; io.bra_stall = 0;
        io.branch_prediction = 0;

        step_cycle();
        step_cycle();
        rst = 1'b0;
        check_output("reset_inst_ready", io.inst_ready, 1);
        check_output("reset_rob_write", io.rob_write, 0);
        check_output("reset_alu_write", io.alu_write, 0);
        check_output("reset_redirect", io.redirect_valid, 0);
        check_output("reset_illegal", io.illegal, 0);
        check_output("reset_history", io.brp_pattern, 0);
        check_output("reset_rob_bus", io.rob_bus, 0);

        // Four back-to-back ADDIs x1..x4 = imm 1..4
        for (int i = 1; i <= 4; i++) begin
            apply_stimulus(enc_addi(i, i), 32'h10 + 32'(4 * i));
            check_output("stream_ready", io.inst_ready, 1);
            check_output("stream_alu_write", io.alu_write, (i > 1));
            if (i > 1) begin
                check_output("stream_alu_imm", io.alu_bus[31:0], i - 1);
                check_output("stream_reg_bus", io.reg_bus, ((i - 1) << 3) | 5);
            end
        end
        step_cycle();
        check_output("stream_last_write", io.alu_write, 1);
        check_output("stream_last_imm", io.alu_bus[31:0], 4);
        step_cycle();
        check_output("stream_idle", io.alu_write, 0);

        // Fill the buffer under alu_stall, then drain
        io.alu_stall = 1; io.reg_data1 = 32'd10; io.reg_data2 = 32'd20;
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(enc_add(5 + i), 32'h40 + 32'(4 * i));
            check_output("fill_ready", io.inst_ready, (i < 3));
            check_output("fill_no_write", io.alu_write, 0);
        end
        apply_stimulus(enc_add(9), 32'h50);
        check_output("fill_fifth_held", io.inst_ready, 0);
        io.alu_stall = 0;
        for (int i = 0; i < 4; i++) begin
            step_cycle();
            check_output("drain_alu_write", io.alu_write, 1);
            check_output("drain_order", io.reg_bus, ((5 + i) << 3) | 5);
            if (i == 0) begin
                check_output("drain_op1", io.alu_bus[67:36], 10);
                check_output("drain_op2", io.alu_bus[31:0], 20);
            end
        end
        step_cycle();
        check_output("drain_no_dup", io.alu_write, 0);

        // BEQ x1,x2,+16 at 0x100, equal operands, with two younger entries behind it
        io.bra_stall = 1; io.reg_data1 = 32'd7; io.reg_data2 = 32'd7;
        apply_stimulus(32'h00208863, 32'h100);
        apply_stimulus(enc_addi(1, 1), 32'h104);
        apply_stimulus(enc_addi(2, 2), 32'h108);
        io.bra_stall = 0;
        step_cycle();
        check_output("beq_rob_write", io.rob_write, 1);
        check_output("beq_resolved", io.rob_bus[65], 1);
        check_output("beq_taken", io.rob_bus[64], 1);
        check_output("beq_bra_write", io.bra_write, 0);
        check_output("beq_redirect", io.redirect_valid, 1);
        check_output("beq_redirect_pc", io.redirect_pc, 32'h110);
        check_output("beq_history", io.brp_pattern, 4'b0001);
        step_cycle();
        check_output("beq_redirect_pulse", io.redirect_valid, 0);
        check_output("beq_drop1", io.alu_write, 0);
        step_cycle();
        check_output("beq_drop2", io.alu_write, 0);

        // BNE with locked rs1 and no forwarding: predicted not-taken
        io.reg_lock1 = 4'b1010; io.rob_value_enable1 = 0; io.branch_prediction = 0;
        apply_stimulus(32'h00209863, 32'h200);
        check_output("bne_rob_entry", io.rob_value_entry1, 3'd2);
        step_cycle();
        check_output("bne_bra_write", io.bra_write, 1);
        check_output("bne_rob_write", io.rob_write, 1);
        check_output("bne_unresolved", io.rob_bus[65], 0);
        check_output("bne_redirect", io.redirect_valid, 0);
        check_output("bne_predicted", io.bra_bus[0], 0);
        check_output("bne_op1_lock", io.bra_bus[104:101], 4'b1010);
        check_output("bne_target", io.bra_bus[32:1], 32'h210);
        check_output("bne_funct3", io.bra_bus[110:108], 3'b001);
        check_output("bne_history", io.brp_pattern, 4'b0010);

        // JALR x1,8(x5) with rs1 forwarded from the ROB: 0x1001+8 with bit0 cleared
        io.reg_lock1 = 4'b1001; io.rob_value_enable1 = 1; io.rob_value1 = 32'h1001;
        apply_stimulus(32'h008280E7, 32'h600);
        step_cycle();
        check_output("jalr_redirect", io.redirect_valid, 1);
        check_output("jalr_redirect_pc", io.redirect_pc, 32'h1008);
        check_output("jalr_no_alu", io.alu_write, 0);
        check_output("jalr_rob_link", io.rob_bus[63:32], 32'h604);
        check_output("jalr_ready", io.inst_ready, 1);
        io.reg_lock1 = '0; io.rob_value_enable1 = 0;

        // JAL x1,+32 at 0x500
        apply_stimulus(32'h020000EF, 32'h500);
        step_cycle();
        check_output("jal_redirect_pc", io.redirect_pc, 32'h520);
        check_output("jal_alu_write", io.alu_write, 1);
        check_output("jal_alu_pc", io.alu_bus[67:36], 32'h500);
        check_output("jal_alu_four", io.alu_bus[31:0], 4);

        // JALR with locked rs1 waits for a flush
        io.reg_lock1 = 4'b1011;
        apply_stimulus(32'h000280E7, 32'h300);
        step_cycle();
        check_output("wjalr_alu_write", io.alu_write, 1);
        check_output("wjalr_simp", io.alu_bus[78:75], 4'd10);
        check_output("wjalr_ready", io.inst_ready, 0);
        check_output("wjalr_redirect", io.redirect_valid, 0);
        apply_stimulus(enc_addi(3, 3), 32'h304);
        check_output("wjalr_blocked_ready", io.inst_ready, 0);
        check_output("wjalr_blocked_alu", io.alu_write, 0);
        io.flush = 1; io.reg_lock1 = '0;
        step_cycle();
        io.flush = 0;
        check_output("flush_ready", io.inst_ready, 1);
        check_output("flush_no_alu", io.alu_write, 0);
        apply_stimulus(enc_addi(3, 3), 32'h400);
        step_cycle();
        check_output("post_flush_alu", io.alu_write, 1);
        check_output("post_flush_imm", io.alu_bus[31:0], 3);

        // Unsupported opcode
        apply_stimulus(32'h00000000, 32'h700);
        step_cycle();
        check_output("illegal_pulse", io.illegal, 1);
        check_output("illegal_no_rob", io.rob_write, 0);
        check_output("illegal_no_alu", io.alu_write, 0);
        step_cycle();
        check_output("illegal_clear", io.illegal, 0);

        // Reset with three stalled entries buffered
        io.alu_stall = 1;
        for (int i = 1; i <= 3; i++) apply_stimulus(enc_addi(i, i), 32'h800 + 32'(4 * i));
        rst = 1'b1;
        step_cycle();
        rst = 1'b0;
        io.alu_stall = 0;
        check_output("rst_ready", io.inst_ready, 1);
        check_output("rst_history", io.brp_pattern, 0);
        check_output("rst_alu", io.alu_write, 0);
        step_cycle();
        check_output("rst_no_alu1", io.alu_write, 0);
        check_output("rst_no_rob1", io.rob_write, 0);
        step_cycle();
        check_output("rst_no_alu2", io.alu_write, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_dispatch.md
DECODE_DISPATCH -- requirements
Module: decode_dispatch

Interface
REQ-001 Parameters (name, default, meaning):
- XLEN, 32, datapath and PC width.
- DEPTH, 4, instruction-buffer entries; power of two, at least 2.
- ROB_W, 3, ROB entry index width; lock width is ROB_W+1.
- BHW, 4, branch-history register width.
- BRA_ADDR_W, 6, PC bits sent to the predictor.
REQ-002 Ports (name, direction, width, meaning; clock and reset first):
- clk in 1: single clock.
- rst in 1: reset, synchronous, active-high.
- inst_valid in 1; inst_in in 32; inst_pc in XLEN: fetch push.
- inst_ready out 1: buffer can accept an instruction.
- flush in 1: ROB mispredict/redirect kill.
- redirect_valid out 1; redirect_pc out XLEN: front-end redirect.
- reg_name1, reg_name2 out 5; reg_lock1, reg_lock2 in ROB_W+1; reg_data1, reg_data2 in XLEN: register-file read.
- rob_value_entry1, rob_value_entry2 out ROB_W; rob_value_enable1, rob_value_enable2 in 1; rob_value1, rob_value2 in XLEN: ROB operand forwarding.
- rob_stall in 1; rob_rd_lock in ROB_W: ROB tail tag.
- rob_write out 1; rob_bus out, width per package: ROB allocate.
- reg_write out 1; reg_bus out 5+ROB_W: rename.
- alu_stall in 1; alu_write out 1; alu_bus out, width per package.
- bra_stall in 1; bra_write out 1; bra_bus out, width per package.
- brp_pattern out BHW; brp_addr out BRA_ADDR_W; branch_prediction in 1: predictor.
- illegal out 1: unsupported-opcode pulse.

Function
REQ-003 Lock encoding: MSB=1 means locked, with the entry index in [ROB_W-1:0]. MSB=0 means no lock.
REQ-004 The buffer is a circular FIFO of {inst, pc}. It pushes on inst_valid && inst_ready. inst_ready = (count < DEPTH), from registered count. Pointers wrap modulo DEPTH.
REQ-005 Only the head entry is decoded. The decode covers RV32I OP, OP-IMM, LUI, AUIPC, JAL, JALR and BRANCH, with the same ALU/branch opcode set as the current decoder.
REQ-006 Operand resolution, per source:
- Unlocked: register-file data.
- Locked and rob_value_enable set: ROB value, marked unlocked.
- Otherwise: the lock is forwarded with data 0.
- OP-IMM/LUI/AUIPC/JAL do not use rs2.
REQ-007 Dispatch fires when all hold: buffer non-empty, state RUN, !flush, !rob_stall, and the target unit is not stalled. BRANCH uses bra_stall; OP, OP-IMM, AUIPC, JAL and locked JALR use alu_stall; LUI and unlocked JALR need only the ROB.
REQ-008 Dispatch pops the head. From that edge, the applicable write strobes are registered high for exactly one cycle; write strobes are otherwise 0. Latency from the head becoming valid to the strobe is 1 cycle.
REQ-009 Bus contents are identical in layout to the current decoder's ROB, ALU, branch and rename buses.
REQ-010 BRANCH with both operands resolved: taken is computed locally, and the ROB entry is marked resolved. Otherwise taken = branch_prediction, and bra_bus carries that prediction. On dispatch, history <= {history[BHW-2:0], taken}.
REQ-011 Redirects on dispatch: a taken BRANCH goes to pc+B-imm, and JAL goes to pc+J-imm. The redirect registers redirect_valid/redirect_pc for one cycle and discards all other buffer entries in the same edge.
REQ-012 JALR with rs1 resolved: the redirect goes to (rs1+imm)&~1, and younger entries are discarded.
REQ-013 JALR with rs1 locked: dispatch to the ALU, discard younger entries, enter WAIT_JALR.
REQ-014 FSM states are RUN and WAIT_JALR:
- WAIT_JALR: no dispatch, inst_ready=0, redirect_valid=0.
- WAIT_JALR -> RUN only on flush.
REQ-015 Unsupported opcode: popped, illegal pulses for 1 cycle, no other strobe.
REQ-016 flush has priority over everything else. It empties the buffer (push that cycle is ignored), zeroes next-cycle strobes, and forces RUN. History is preserved.
REQ-017 Arithmetic is modulo 2^XLEN. Immediates are sign-extended to XLEN.

Reset
REQ-018 Synchronous, rst high at posedge clk. Resulting state:
- Buffer empty; inst_ready=1 the cycle after.
- State RUN; history 0.
- All strobes, redirect_valid and illegal are 0; buses are 0.
REQ-019 Reset mid-operation discards buffered instructions and any WAIT_JALR state without emitting strobes.

Structure
REQ-020 A shared package holds the opcode/func constants, simp_op codes, ROB entry-kind codes, the lock encoding, and the bus-width/field-offset localparams.
REQ-021 Sub-module inst_fifo (parametrised XLEN+32 wide by DEPTH) implements the buffer. Decode, operand resolution and dispatch live in decode_dispatch.

Verification
REQ-022 Push 4 ADDIs (x1=x0+1 ... x4=x0+4) with no stalls -> 4 consecutive alu_write pulses, first one cycle after the first push; inst_ready stays 1.
REQ-023 alu_stall=1 and push 5 OPs at DEPTH=4 -> inst_ready=0 after the 4th; the 5th is held by fetch. Release the stall -> 4 dispatches in order, no loss or duplicate.
REQ-024 BEQ x1,x2,+16 at pc 0x100 with both unlocked and equal -> rob_write with resolved flag, bra_write=0, redirect_pc=0x110, younger entries dropped, history=0001.
REQ-025 BNE with rs1 lock=0b1010, rob_value_enable1=0, branch_prediction=0 -> bra_write=1 with predicted 0, no redirect, history shifts in 0.
REQ-026 JALR with locked rs1 -> alu_write=1, state WAIT_JALR, inst_ready=0. Assert flush -> RUN, buffer empty, next push dispatches normally.
REQ-027 Assert rst while 3 entries are buffered and alu_stall=1 -> no strobes after reset, inst_ready=1, history=0.
